// File: rtl/ps2_frame_rx.sv
// ============================================================================
// Module   : ps2_frame_rx
// Function : PS/2 device-to-host receiver; deframes 11-bit frames into a
//            two-byte keycode with parity/stop/timeout error pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_frame_rx #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        kclk,
    input  logic        kdata,
    output logic [15:0] keycode,
    output logic        oflag,
    output logic        parity_err,
    output logic        frame_err
);

    localparam int         c_TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0] c_FILT_MAX = 4'(FILTER_LEN - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
    localparam logic [1:0] c_ST_PARITY = 2'd2;
    localparam logic [1:0] c_ST_STOP   = 2'd3;

    logic               r_kclk_s1;
    logic               r_kclk_s2;
    logic               r_kdata_s1;
    logic               r_kdata_s2;
    logic               r_kclk_filt;
    logic               r_kclk_filt_q;
    logic [3:0]         r_filt_cnt;
    logic [1:0]         r_state;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shreg;
    logic               r_parity;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic [15:0]        r_keycode;
    logic               r_oflag;
    logic               r_parity_err;
    logic               r_frame_err;

    logic               w_fall;
    logic               w_timeout;
    logic [1:0]         w_state_next;
    logic               w_accept;
    logic               w_perr;
    logic               w_ferr;

    // Two-flop synchronisers; idle PS/2 lines are high, so they reset to 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_kclk_s1  <= 1'b1;
            r_kclk_s2  <= 1'b1;
            r_kdata_s1 <= 1'b1;
            r_kdata_s2 <= 1'b1;
        end else begin
            r_kclk_s1  <= kclk;
            r_kclk_s2  <= r_kclk_s1;
            r_kdata_s1 <= kdata;
            r_kdata_s2 <= r_kdata_s1;
        end
    end

    // Filtered clock follows the synchronised clock only after it has held
    // the new level for FILTER_LEN consecutive cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_kclk_filt   <= 1'b1;
            r_kclk_filt_q <= 1'b1;
            r_filt_cnt    <= 4'd0;
        end else begin
            r_kclk_filt_q <= r_kclk_filt;
            if (r_kclk_s2 == r_kclk_filt) begin
                r_filt_cnt <= 4'd0;
            end else if (r_filt_cnt == c_FILT_MAX) begin
                r_kclk_filt <= r_kclk_s2;
                r_filt_cnt  <= 4'd0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 4'd1;
            end
        end
    end

    assign w_fall    = r_kclk_filt_q & ~r_kclk_filt;
    assign w_timeout = (r_state != c_ST_IDLE) && !w_fall && (r_tmo_cnt == c_TMO_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_perr       = 1'b0;
        w_ferr       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_fall && !r_kdata_s2) begin
                    w_state_next = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_fall && (r_bit_cnt == 3'd7)) begin
                    w_state_next = c_ST_PARITY;
                end
            end
            c_ST_PARITY: begin
                if (w_fall) begin
                    w_state_next = c_ST_STOP;
                end
            end
            c_ST_STOP: begin
                if (w_fall) begin
                    w_state_next = c_ST_IDLE;
                    // A bad stop bit outranks a parity error.
                    if (!r_kdata_s2) begin
                        w_ferr = 1'b1;
                    end else if (^{r_shreg, r_parity}) begin
                        w_accept = 1'b1;
                    end else begin
                        w_perr = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
        if (w_timeout) begin
            w_state_next = c_ST_IDLE;
            w_ferr       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bit_cnt <= 3'd0;
            r_shreg   <= 8'h00;
            r_parity  <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            if (w_fall && (r_state == c_ST_IDLE)) begin
                r_bit_cnt <= 3'd0;
            end else if (w_fall && (r_state == c_ST_DATA)) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shreg   <= {r_kdata_s2, r_shreg[7:1]};
            end
            if (w_fall && (r_state == c_ST_PARITY)) begin
                r_parity <= r_kdata_s2;
            end
            if ((r_state == c_ST_IDLE) || w_fall) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_keycode    <= 16'h0000;
            r_oflag      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_oflag      <= w_accept;
            r_parity_err <= w_perr;
            r_frame_err  <= w_ferr;
            if (w_accept) begin
                r_keycode <= {r_keycode[7:0], r_shreg};
            end
        end
    end

    assign keycode    = r_keycode;
    assign oflag      = r_oflag;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_frame_rx.sv
// ============================================================================
// Module   : tb_ps2_frame_rx
// Function : Scoreboard bench for ps2_frame_rx with a frame-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_frame_rx;

    localparam int FL  = 4;
    localparam int TMO = 2000;

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic        kclk  = 1'b1;
    logic        kdata = 1'b1;
    logic [15:0] keycode;
    logic        oflag;
    logic        parity_err;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    // kind: 0 accepted byte, 1 parity error, 2 frame error
    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] kc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_kc = 16'h0000;
    exp_t        mon_e;
    int          mon_kind;

    ps2_frame_rx #(
        .FILTER_LEN (FL),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .kclk      (kclk),
        .kdata     (kdata),
        .keycode   (keycode),
        .oflag     (oflag),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rstn && (oflag || parity_err || frame_err)) begin
            chk("onehot", 32'(int'(oflag) + int'(parity_err) + int'(frame_err)), 32'd1);
            mon_kind = oflag ? 0 : (parity_err ? 1 : 2);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got kind %0d keycode %0h expected none", mon_kind, keycode);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_kind", 32'(mon_kind), 32'(mon_e.kind));
                chk("keycode", 32'(keycode), 32'(mon_e.kc));
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives nbits of a frame LSB-first; optional short kclk glitch in each high phase.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int h, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            kdata = bits[i];
            if (glitch) begin
                wait_clk(3);
                kclk = 1'b0;
                wait_clk($urandom_range(1, FL - 1));
                kclk = 1'b1;
            end
            wait_clk(h);
            kclk = 1'b0;
            wait_clk(h);
            kclk = 1'b1;
        end
        kdata = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input int h, input bit glitch);
        logic par;
        exp_t e;
        par = ~(^d) ^ bad_par;
        if (bad_stop) begin
            e.kind = 2'd2;
        end else if (bad_par) begin
            e.kind = 2'd1;
        end else begin
            e.kind   = 2'd0;
            model_kc = {model_kc[7:0], d};
        end
        e.kc = model_kc;
        sb.push_back(e);
        send_bits({~bad_stop, par, d, 1'b0}, 11, h, glitch);
        wait_clk(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_keycode"}, 32'(keycode), 32'h0);
        chk({tag, "_oflag"}, 32'(oflag), 32'h0);
        chk({tag, "_parity_err"}, 32'(parity_err), 32'h0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    endtask

    initial begin
        exp_t e;
        wait_clk(3);
        check_reset_outputs("reset");
        rstn = 1'b1;
        wait_clk(5);

        send_frame(8'h1C, 0, 0, 15, 0);
        send_frame(8'hF0, 0, 0, 15, 0);
        send_frame(8'h1C, 0, 0, 12, 0);
        send_frame(8'h1D, 1, 0, 15, 0);
        send_frame(8'h22, 0, 0, 15, 0);
        send_frame(8'h1C, 0, 1, 15, 0);

        // Start bit plus four data bits, then silence until the timeout fires.
        e.kind = 2'd2;
        e.kc   = model_kc;
        sb.push_back(e);
        send_bits({2'b11, 8'h5A, 1'b0}, 5, 15, 0);
        wait_clk(TMO + 50);
        chk("timeout_pulse_seen", 32'(sb.size()), 32'd0);
        send_frame(8'h75, 0, 0, 15, 0);

        for (int g = 1; g < FL; g++) begin
            kclk = 1'b0;
            wait_clk(g);
            kclk = 1'b1;
            wait_clk(10);
        end
        send_frame(8'h5A, 0, 0, 15, 1);

        // Reset in the middle of a frame.
        send_bits({2'b11, 8'h33, 1'b0}, 6, 15, 0);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        wait_clk(3);
        rstn     = 1'b1;
        model_kc = 16'h0000;
        wait_clk(5);
        send_frame(8'h29, 0, 0, 15, 0);

        for (int n = 0; n < 40; n++) begin
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 5) == 0), $urandom_range(8, 25),
                       ($urandom_range(0, 3) == 0));
            wait_clk($urandom_range(0, 12));
        end

        for (int t = 0; t < 200 && sb.size() != 0; t++) begin
            wait_clk(1);
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        wait_clk(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
